// File: rtl/spi_master_multi_if.sv
// ----------------------------------------------------------------------------
// spi_master_multi_if
//   Bundles the host strobe interface and the SPI pin signals of
//   spi_master_multi so one handle carries the whole bus.
//
// Parameters
//   BITS    word length in bits
//   NUM_SS  number of active-low slave-select lines
//   SS_W    width of the slave index; defaults to $clog2(NUM_SS), or 1 when
//           NUM_SS is 1. It can be made wider so that indices beyond NUM_SS-1
//           can be presented.
//
// Signals
//   cpol, cpha   SPI mode inputs (host -> master)
//   ss_sel       target slave index (host -> master)
//   data_ready   start strobe (host -> master)
//   data_in      transmit word (host -> master)
//   data_out     last received word (master -> host)
//   data_sent    one-cycle completion pulse (master -> host)
//   busy         transfer in progress (master -> host)
//   sclk, mosi   SPI clock and data out (master -> slave)
//   miso         SPI data in (slave -> master)
//   ss_n         active-low one-cold slave selects (master -> slave)
//
// Modports
//   master  the view seen by spi_master_multi
//   slave   the opposite view, used by whatever drives the host inputs and miso
//
// Handshake: data_ready is a single-cycle start request that is taken only
// while the master is idle (busy low); it is dropped, not queued, otherwise.
// data_sent marks the one cycle in which data_out first holds the new word.
// ----------------------------------------------------------------------------
interface spi_master_multi_if #(
    parameter int BITS   = 8,
    parameter int NUM_SS = 4,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
    logic              cpol;
    logic              cpha;
    logic [SS_W-1:0]   ss_sel;
    logic              data_ready;
    logic [BITS-1:0]   data_in;
    logic [BITS-1:0]   data_out;
    logic              data_sent;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;

    modport master (
        input  cpol, cpha, ss_sel, data_ready, data_in, miso,
        output data_out, data_sent, busy, sclk, mosi, ss_n
    );

    modport slave (
        output cpol, cpha, ss_sel, data_ready, data_in, miso,
        input  data_out, data_sent, busy, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_multi.sv
// ----------------------------------------------------------------------------
// spi_master_multi
//   Parametrised SPI master. Runs one BITS-wide full-duplex transfer per
//   accepted strobe, in any of the four CPOL/CPHA modes, with an SCLK
//   half-period of CLK_DIV system clocks and one of NUM_SS active-low selects.
//
// Parameters
//   BITS     word length (>= 2)
//   NUM_SS   number of slave selects (>= 1)
//   CLK_DIV  clk cycles per SCLK half-period (>= 1)
//   SS_W     width of ss_sel; must match the connected interface
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        spi_master_multi_if.master: host strobe interface + SPI pins
//   fsm_state  current FSM state (debug observation only)
//
// Build option
//   SPI_LSB_FIRST_EN  when defined, words go out on mosi and come in from
//                     miso least-significant bit first; otherwise MSB first.
//                     Ports and timing are identical either way.
//
// Sequence: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
//   SETUP and HOLD each last CLK_DIV cycles with sclk at its idle level and
//   the selected ss_n low. XFER produces 2*BITS sclk edges, one every CLK_DIV
//   cycles. DONE lasts one cycle: selects released, data_out loaded,
//   data_sent pulsed. A strobe at cycle 0 gives data_sent at cycle
//   1 + CLK_DIV*(2*BITS+2).
// ----------------------------------------------------------------------------
module spi_master_multi #(
    parameter int BITS    = 8,
    parameter int NUM_SS  = 4,
    parameter int CLK_DIV = 2,
    parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_multi_if.master  bus,
    output logic [2:0]          fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Edge counter holds 0 .. 2*BITS-1.
    localparam int EDGE_W = $clog2(2 * BITS) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * BITS - 1);

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [BITS-1:0]    tx_sh;
    logic [BITS-1:0]    rx_sh;
    logic               cpol_q;
    logic               cpha_q;

    // The edge about to be produced is a leading edge when an even number of
    // edges has already gone out. Sampling happens on leading edges in
    // cpha=0 and on trailing edges in cpha=1; every other edge is a shift edge.
    logic lead_edge;
    logic sample_edge;

    assign lead_edge   = ~edge_cnt[0];
    assign sample_edge = lead_edge ^ cpha_q;
    assign fsm_state   = state;

    // ---- bit-order helpers ------------------------------------------------
    function automatic logic first_bit(input logic [BITS-1:0] w);
`ifdef SPI_LSB_FIRST_EN
        return w[0];
`else
        return w[BITS-1];
`endif
    endfunction

    function automatic logic [BITS-1:0] tx_shift(input logic [BITS-1:0] w);
`ifdef SPI_LSB_FIRST_EN
        return w >> 1;
`else
        return w << 1;
`endif
    endfunction

    function automatic logic [BITS-1:0] rx_shift(input logic [BITS-1:0] w,
                                                 input logic          b);
`ifdef SPI_LSB_FIRST_EN
        return {b, w[BITS-1:1]};
`else
        return {w[BITS-2:0], b};
`endif
    endfunction

    // An index with no matching line leaves every select high; the transfer
    // still runs with normal timing.
    function automatic logic [NUM_SS-1:0] decode(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] dec;
        for (int i = 0; i < NUM_SS; i++) begin
            dec[i] = (32'(sel) != 32'(i));
        end
        return dec;
    endfunction

    // ---- single FSM, all outputs registered --------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            edge_cnt      <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            bus.sclk      <= 1'b0;
            bus.mosi      <= 1'b0;
            bus.ss_n      <= '1;
            bus.busy      <= 1'b0;
            bus.data_sent <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            bus.data_sent <= 1'b0;

            case (state)
                S_IDLE: begin
                    // sclk follows cpol while idle so the slave sees the
                    // correct idle level before select goes low.
                    bus.sclk <= bus.cpol;
                    bus.busy <= 1'b0;
                    if (bus.data_ready) begin
                        cpol_q   <= bus.cpol;
                        cpha_q   <= bus.cpha;
                        tx_sh    <= bus.data_in;
                        bus.mosi <= first_bit(bus.data_in);
                        bus.ss_n <= decode(bus.ss_sel);
                        bus.busy <= 1'b1;
                        rx_sh    <= '0;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    bus.sclk <= cpol_q;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= S_XFER;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_XFER: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        bus.sclk <= ~bus.sclk;
                        edge_cnt <= edge_cnt + EDGE_W'(1);

                        if (sample_edge) begin
                            rx_sh <= rx_shift(rx_sh, bus.miso);
                        end else if (cpha_q) begin
                            // cpha=1: the first leading edge presents the bit
                            // already on mosi; later leading edges advance.
                            if (edge_cnt != '0) begin
                                tx_sh    <= tx_shift(tx_sh);
                                bus.mosi <= first_bit(tx_shift(tx_sh));
                            end
                        end else if (edge_cnt != EDGE_LAST) begin
                            // cpha=0: advance on trailing edges, none after
                            // the final edge.
                            tx_sh    <= tx_shift(tx_sh);
                            bus.mosi <= first_bit(tx_shift(tx_sh));
                        end

                        if (edge_cnt == EDGE_LAST) begin
                            state <= S_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_HOLD: begin
                    bus.sclk <= cpol_q;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt       <= '0;
                        bus.ss_n      <= '1;
                        bus.data_out  <= rx_sh;
                        bus.data_sent <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    bus.ss_n <= '1;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
